// File: rtl/qmca_conf_mc_if.sv
// Bus strobe/address bundle for the qmca_conf_mc register block.
// Ports: bus_rd, bus_wr (strobes), bus_add (ABUSWIDTH address);
// the 8-bit tristate data line stays a plain inout on the block.
interface qmca_conf_mc_if #(
    parameter int ABUSWIDTH = 16
);
    logic                 bus_rd;
    logic                 bus_wr;
    logic [ABUSWIDTH-1:0] bus_add;

    modport master (output bus_rd, output bus_wr, output bus_add);
    modport slave  (input  bus_rd, input  bus_wr, input  bus_add);
endinterface

// File: rtl/qmca_conf_mc.sv
// Shadowed configuration registers with commit, stretched conf_rst and a
// saturating event counter with coherent 16-bit reads over an 8-bit bus.
// Ports: clk, rst (sync, active-high); bus (rd/wr/add), bus_data (inout);
// sm_channel/sm_data status, evt_strobe; conf_* active configuration outputs.
module qmca_conf_mc #(
    parameter int          BASEADDR      = 0,
    parameter int          HIGHADDR      = 0,
    parameter int          ABUSWIDTH     = 16,
    parameter int          DBUSWIDTH     = 8,
    parameter int          NCH           = 4,
    parameter int          THR_WIDTH     = 14,
    parameter int          RST_STRETCH   = 4,
    parameter logic [15:0] DEF_THRESHOLD = 16'h3FFF,
    parameter logic [7:0]  DEF_EN_MASK   = 8'hFF,
    parameter logic [7:0]  DEF_BUF_SIZE  = 8'h7F,
    parameter logic [15:0] DEF_EVT_SIZE  = 16'h03FF
) (
    input  logic                       clk,
    input  logic                       rst,
    qmca_conf_mc_if.slave              bus,
    inout  wire  [DBUSWIDTH-1:0]       bus_data,
    input  logic [1:0]                 sm_channel,
    input  logic                       sm_data,
    input  logic                       evt_strobe,
    output logic                       conf_rst,
    output logic                       conf_pending,
    output logic [NCH-1:0]             conf_en_mask,
    output logic [NCH*THR_WIDTH-1:0]   conf_threshold,
    output logic [7:0]                 conf_buf_size,
    output logic [11:0]                conf_evt_size
);
    localparam logic [THR_WIDTH-1:0] DEF_THR = DEF_THRESHOLD[THR_WIDTH-1:0];
    localparam logic [NCH-1:0]       DEF_EN  = DEF_EN_MASK[NCH-1:0];
    localparam logic [11:0]          DEF_EVT = DEF_EVT_SIZE[11:0];
    localparam logic [7:0]           RST_LD  = 8'(RST_STRETCH);

    localparam logic [ABUSWIDTH-1:0] O_SRST = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] O_STAT = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] O_MASK = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] O_CTRL = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] O_BUF  = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] O_EVTL = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] O_EVTH = ABUSWIDTH'(6);
    localparam logic [ABUSWIDTH-1:0] O_CNTL = ABUSWIDTH'(8);
    localparam logic [ABUSWIDTH-1:0] O_CNTH = ABUSWIDTH'(9);

    logic [NCH-1:0]       en_sh_q, en_sh_d, en_act_q, en_act_d;
    logic [THR_WIDTH-1:0] thr_sh_q [NCH];
    logic [THR_WIDTH-1:0] thr_sh_d [NCH];
    logic [THR_WIDTH-1:0] thr_act_q [NCH];
    logic [THR_WIDTH-1:0] thr_act_d [NCH];
    logic [7:0]           buf_sh_q, buf_sh_d, buf_act_q, buf_act_d;
    logic [11:0]          evt_sh_q, evt_sh_d, evt_act_q, evt_act_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [7:0]           snap_q, snap_d;
    logic [7:0]           rd_q, rd_d;
    logic                 pend_q, pend_d;
    logic [7:0]           rcnt_q, rcnt_d;

    logic [ABUSWIDTH-1:0] off;
    logic                 valid, wr_en, rd_en;
    logic [7:0]           wdat;
    logic                 chg;
    logic [15:0]          t16;

    // Subtracting first makes addresses below BASEADDR wrap to large values,
    // so a single upper-bound compare covers both ends of the window.
    assign off   = bus.bus_add - ABUSWIDTH'(BASEADDR);
    assign valid = (off <= ABUSWIDTH'(HIGHADDR - BASEADDR));
    assign wr_en = valid && bus.bus_wr;
    assign rd_en = valid && bus.bus_rd && !bus.bus_wr;
    assign wdat  = bus_data[7:0];

    assign bus_data = (valid && !bus.bus_wr) ? rd_q : {DBUSWIDTH{1'bz}};

    always_comb begin
        en_sh_q_to_d: begin
            en_sh_d   = en_sh_q;
            en_act_d  = en_act_q;
            thr_sh_d  = thr_sh_q;
            thr_act_d = thr_act_q;
            buf_sh_d  = buf_sh_q;
            buf_act_d = buf_act_q;
            evt_sh_d  = evt_sh_q;
            evt_act_d = evt_act_q;
            snap_d    = snap_q;
            rd_d      = rd_q;
            pend_d    = pend_q;
        end
        chg = 1'b0;
        t16 = 16'h0000;

        cnt_d = cnt_q;
        if (evt_strobe && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end

        rcnt_d = (rcnt_q != 8'd0) ? rcnt_q - 8'd1 : 8'd0;

        if (rd_en) begin
            rd_d = 8'h00;
            case (off)
                O_STAT: rd_d = {5'b0, sm_data, sm_channel};
                O_MASK: rd_d = 8'(en_sh_q);
                O_CTRL: rd_d = {7'b0, pend_q};
                O_BUF:  rd_d = buf_sh_q;
                O_EVTL: rd_d = evt_sh_q[7:0];
                O_EVTH: rd_d = {4'b0, evt_sh_q[11:8]};
                O_CNTL: begin
                    rd_d   = cnt_q[7:0];
                    snap_d = cnt_q[15:8];
                end
                O_CNTH: begin
                    rd_d  = snap_q;
                    // Clear on high-byte read; a coincident strobe survives.
                    cnt_d = {15'b0, evt_strobe};
                end
                default: rd_d = 8'h00;
            endcase
            for (int c = 0; c < NCH; c++) begin
                t16 = 16'(thr_sh_q[c]);
                if (off == ABUSWIDTH'(16 + 2 * c)) rd_d = t16[7:0];
                if (off == ABUSWIDTH'(17 + 2 * c)) rd_d = t16[15:8];
            end
        end

        if (wr_en) begin
            case (off)
                O_MASK: begin
                    en_sh_d = wdat[NCH-1:0];
                    chg     = (wdat[NCH-1:0] != en_sh_q);
                end
                O_CTRL: begin
                    if (wdat[0]) begin
                        en_act_d  = en_sh_q;
                        thr_act_d = thr_sh_q;
                        buf_act_d = buf_sh_q;
                        evt_act_d = evt_sh_q;
                        pend_d    = 1'b0;
                        rcnt_d    = RST_LD;
                    end
                end
                O_BUF: begin
                    buf_sh_d = wdat;
                    chg      = (wdat != buf_sh_q);
                end
                O_EVTL: begin
                    evt_sh_d[7:0] = wdat;
                    chg           = (wdat != evt_sh_q[7:0]);
                end
                O_EVTH: begin
                    evt_sh_d[11:8] = wdat[3:0];
                    chg            = (wdat[3:0] != evt_sh_q[11:8]);
                end
                default: ;
            endcase
            for (int c = 0; c < NCH; c++) begin
                t16 = 16'(thr_sh_q[c]);
                if (off == ABUSWIDTH'(16 + 2 * c)) t16[7:0] = wdat;
                if (off == ABUSWIDTH'(17 + 2 * c)) t16[15:8] = wdat;
                thr_sh_d[c] = THR_WIDTH'(t16);
                if (thr_sh_d[c] != thr_sh_q[c]) chg = 1'b1;
            end
        end

        if (chg) pend_d = 1'b1;

        if (wr_en && off == O_SRST) begin
            en_sh_d   = DEF_EN;
            en_act_d  = DEF_EN;
            thr_sh_d  = '{default: DEF_THR};
            thr_act_d = '{default: DEF_THR};
            buf_sh_d  = DEF_BUF_SIZE;
            buf_act_d = DEF_BUF_SIZE;
            evt_sh_d  = DEF_EVT;
            evt_act_d = DEF_EVT;
            cnt_d     = 16'h0000;
            snap_d    = 8'h00;
            pend_d    = 1'b0;
            rcnt_d    = RST_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_sh_q   <= DEF_EN;
            en_act_q  <= DEF_EN;
            thr_sh_q  <= '{default: DEF_THR};
            thr_act_q <= '{default: DEF_THR};
            buf_sh_q  <= DEF_BUF_SIZE;
            buf_act_q <= DEF_BUF_SIZE;
            evt_sh_q  <= DEF_EVT;
            evt_act_q <= DEF_EVT;
            cnt_q     <= 16'h0000;
            snap_q    <= 8'h00;
            rd_q      <= 8'h00;
            pend_q    <= 1'b0;
            rcnt_q    <= RST_LD;
        end else begin
            en_sh_q   <= en_sh_d;
            en_act_q  <= en_act_d;
            thr_sh_q  <= thr_sh_d;
            thr_act_q <= thr_act_d;
            buf_sh_q  <= buf_sh_d;
            buf_act_q <= buf_act_d;
            evt_sh_q  <= evt_sh_d;
            evt_act_q <= evt_act_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            rd_q      <= rd_d;
            pend_q    <= pend_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_comb begin
        conf_threshold = '0;
        for (int c = 0; c < NCH; c++) begin
            conf_threshold[c*THR_WIDTH +: THR_WIDTH] = thr_act_q[c];
        end
    end

    assign conf_rst      = (rcnt_q != 8'd0);
    assign conf_pending  = pend_q;
    assign conf_en_mask  = en_act_q;
    assign conf_buf_size = buf_act_q;
    assign conf_evt_size = evt_act_q;
endmodule

// File: tb/tb_qmca_conf_mc.sv
// Directed bench for qmca_conf_mc: reset values, shadow/commit, counter
// snapshot and saturation, soft reset, rd/wr collision and address window.
module tb_qmca_conf_mc;
    localparam logic [15:0] IDLE = 16'h0100;
    localparam logic [15:0] OOR  = 16'h0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sm_channel = 2'b00;
    logic        sm_data = 1'b0;
    logic        evt_strobe = 1'b1;
    logic        conf_rst, conf_pending;
    logic [3:0]  conf_en_mask;
    logic [55:0] conf_threshold;
    logic [7:0]  conf_buf_size;
    logic [11:0] conf_evt_size;
    logic [7:0]  drv = 8'h00;
    logic        oe = 1'b0;
    tri1  [7:0]  bus_data;
    int          total = 0;
    int          bad = 0;
    int          n;
    logic [7:0]  r;

    assign bus_data = oe ? drv : 8'hzz;

    qmca_conf_mc_if #(.ABUSWIDTH(16)) bus_if ();

    qmca_conf_mc #(
        .BASEADDR(0), .HIGHADDR(32'h1F), .ABUSWIDTH(16), .DBUSWIDTH(8),
        .NCH(4), .THR_WIDTH(14), .RST_STRETCH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .bus_data(bus_data),
        .sm_channel(sm_channel), .sm_data(sm_data),
        .evt_strobe(evt_strobe), .conf_rst(conf_rst),
        .conf_pending(conf_pending), .conf_en_mask(conf_en_mask),
        .conf_threshold(conf_threshold), .conf_buf_size(conf_buf_size),
        .conf_evt_size(conf_evt_size)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.bus_add = a;
        drv = d;
        oe = 1'b1;
        bus_if.bus_wr = 1'b1;
        @(negedge clk);
        bus_if.bus_wr = 1'b0;
        oe = 1'b0;
        bus_if.bus_add = IDLE;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.bus_add = a;
        bus_if.bus_rd = 1'b1;
        @(posedge clk);
        #1 d = bus_data;
        @(negedge clk);
        bus_if.bus_rd = 1'b0;
        bus_if.bus_add = IDLE;
    endtask

    // Counts conf_rst-high negedges, starting at the current one.
    task automatic rst_len(output int cnt);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (conf_rst) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus_if.bus_rd = 1'b0;
        bus_if.bus_wr = 1'b0;
        bus_if.bus_add = IDLE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        evt_strobe = 1'b0;

        // reset state
        chk("rst_pend", conf_pending, 0);
        chk("rst_thr", conf_threshold, {4{14'h3FFF}});
        chk("rst_mask", conf_en_mask, 4'hF);
        chk("rst_buf", conf_buf_size, 8'h7F);
        chk("rst_evt", conf_evt_size, 12'h3FF);
        rst_len(n);
        chk("rst_stretch", n, 4);
        rd(16'h8, r); chk("rst_cnt_lo", r, 8'h00);
        rd(16'h9, r); chk("rst_cnt_hi", r, 8'h00);

        // shadow writes and commit
        wr(16'h12, 8'h34);
        chk("pend_set", conf_pending, 1);
        wr(16'h13, 8'h12);
        wr(16'h15, 8'hC1);
        chk("ch1_hold", conf_threshold[27:14], 14'h3FFF);
        rd(16'h12, r); chk("thr1_lo", r, 8'h34);
        rd(16'h13, r); chk("thr1_hi", r, 8'h12);
        rd(16'h15, r); chk("thr2_hi_mask", r, 8'h01);
        rd(16'h3, r);  chk("ctrl_pend", r, 8'h01);
        wr(16'h3, 8'h01);
        chk("ch1_commit", conf_threshold[27:14], 14'h1234);
        chk("ch2_commit", conf_threshold[41:28], 14'h01FF);
        chk("ch0_commit", conf_threshold[13:0], 14'h3FFF);
        chk("pend_clr", conf_pending, 0);
        rst_len(n);
        chk("commit_stretch", n, 4);

        // status, buf/evt size
        sm_channel = 2'b10;
        sm_data = 1'b1;
        rd(16'h1, r); chk("status", r, 8'h06);
        wr(16'h4, 8'h20);
        wr(16'h5, 8'hAB);
        wr(16'h6, 8'hFD);
        rd(16'h6, r); chk("evt_hi_rd", r, 8'h0D);
        chk("evt_hold", conf_evt_size, 12'h3FF);
        wr(16'h3, 8'h01);
        chk("evt_commit", conf_evt_size, 12'hDAB);
        chk("buf_commit", conf_buf_size, 8'h20);

        // mask width, then soft reset
        wr(16'h2, 8'hF5);
        rd(16'h2, r); chk("mask_rd", r, 8'h05);
        chk("mask_hold", conf_en_mask, 4'hF);
        wr(16'h0, 8'h00);
        chk("srst_crst", conf_rst, 1);
        chk("srst_pend", conf_pending, 0);
        chk("srst_thr", conf_threshold, {4{14'h3FFF}});
        chk("srst_evt", conf_evt_size, 12'h3FF);
        chk("srst_buf", conf_buf_size, 8'h7F);
        rd(16'h2, r);  chk("srst_mask_sh", r, 8'h0F);
        rd(16'h13, r); chk("srst_thr_sh", r, 8'h3F);

        // coherent snapshot: 0x00FF, read lo, +1, read hi
        @(negedge clk);
        evt_strobe = 1'b1;
        repeat (255) @(negedge clk);
        evt_strobe = 1'b0;
        rd(16'h8, r); chk("snap_lo", r, 8'hFF);
        @(negedge clk);
        evt_strobe = 1'b1;
        @(negedge clk);
        evt_strobe = 1'b0;
        rd(16'h9, r); chk("snap_hi", r, 8'h00);
        rd(16'h8, r); chk("clr_after_hi", r, 8'h00);

        // saturation
        @(negedge clk);
        evt_strobe = 1'b1;
        repeat (70000) @(negedge clk);
        evt_strobe = 1'b0;
        rd(16'h8, r); chk("sat_lo", r, 8'hFF);
        rd(16'h9, r); chk("sat_hi", r, 8'hFF);
        rd(16'h8, r); chk("sat_clr", r, 8'h00);

        // strobe coincident with hi read counts as one
        @(negedge clk);
        bus_if.bus_add = 16'h9;
        bus_if.bus_rd = 1'b1;
        evt_strobe = 1'b1;
        @(negedge clk);
        bus_if.bus_rd = 1'b0;
        evt_strobe = 1'b0;
        bus_if.bus_add = IDLE;
        rd(16'h8, r); chk("clr_evt_one", r, 8'h01);

        // rd+wr collision: write wins, read data holds
        rd(16'h1, r); chk("status2", r, 8'h06);
        @(negedge clk);
        bus_if.bus_add = 16'h2;
        drv = 8'h03;
        oe = 1'b1;
        bus_if.bus_rd = 1'b1;
        bus_if.bus_wr = 1'b1;
        @(negedge clk);
        bus_if.bus_rd = 1'b0;
        bus_if.bus_wr = 1'b0;
        oe = 1'b0;
        #1 r = bus_data;
        chk("rdwr_hold", r, 8'h06);
        bus_if.bus_add = IDLE;
        chk("rdwr_pend", conf_pending, 1);
        rd(16'h2, r); chk("rdwr_wrote", r, 8'h03);

        // out of window
        rd(OOR, r); chk("oor_hiz", r, 8'hFF);
        wr(OOR, 8'h00);
        chk("oor_no_srst", conf_rst, 0);
        chk("oor_pend", conf_pending, 1);
        rd(16'h2, r); chk("oor_mask", r, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
